// File: rtl/gate_vector_tester_if.sv
// Bus between gate_vector_tester and whoever drives its run controls and DUT output.
// GVT_FIRST_FAIL_CAPTURE_EN adds the first-failing-vector capture signals.
interface gate_vector_tester_if #(
  parameter int N_IN  = 2,
  parameter int ERR_W = 8
);
  logic             start;
  logic [2:0]       mode;
  logic             dut_out;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [N_IN-1:0]  fail_vec;

  modport master (
    output start, mode, dut_out,
    input  stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
  modport slave (
    input  start, mode, dut_out,
    output stim, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
`else
  modport master (
    output start, mode, dut_out,
    input  stim, busy, done, pass, err_cnt
  );
  modport slave (
    input  start, mode, dut_out,
    output stim, busy, done, pass, err_cnt
  );
`endif
endinterface

// File: rtl/gate_vector_tester.sv
// Exhaustive vector driver and checker for an N_IN-input combinational gate.
// Optional macro GVT_FIRST_FAIL_CAPTURE_EN enables first-failing-vector capture.
module gate_vector_tester #(
  parameter int N_IN  = 2,
  parameter int HOLD  = 100,
  parameter int ERR_W = 8
) (
  input logic            clk,
  input logic            rst,
  gate_vector_tester_if.slave bus
);

  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("gate_vector_tester: N_IN must be in 1..8");
  end
  if (HOLD < 1 || HOLD > 65535) begin : g_bad_hold
    $error("gate_vector_tester: HOLD must be in 1..65535");
  end
  if (ERR_W < 1) begin : g_bad_err_w
    $error("gate_vector_tester: ERR_W must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  localparam logic [N_IN-1:0]  STIM_ONES = '1;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [15:0]      HOLD_LAST = 16'(HOLD - 1);

  state_t           state_q, state_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [15:0]      hold_cnt_q, hold_cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
  logic             fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]  fail_vec_q, fail_vec_d;
`endif

  function automatic logic ref_fn(input logic [2:0] m, input logic [N_IN-1:0] v);
    case (m)
      3'd0:    ref_fn = &v;
      3'd1:    ref_fn = |v;
      3'd2:    ref_fn = ^v;
      3'd3:    ref_fn = ~&v;
      3'd4:    ref_fn = ~|v;
      3'd5:    ref_fn = ~^v;
      3'd6:    ref_fn = v[0];
      default: ref_fn = ~v[0];
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
`endif
    expected = ref_fn(mode_q, stim_q);
    mismatch = (bus.dut_out != expected);
    err_next = (mismatch && err_cnt_q != ERR_MAX) ? err_cnt_q + 1'b1 : err_cnt_q;

    case (state_q)
      IDLE, DONE: begin
        // A new run may begin from idle or straight from a finished run.
        if (bus.start) begin
          state_d    = APPLY;
          mode_d     = bus.mode;
          stim_d     = '0;
          hold_cnt_d = '0;
          err_cnt_d  = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
`endif
        end
      end
      APPLY: begin
        hold_cnt_d = hold_cnt_q + 16'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        err_cnt_d = err_next;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
        if (mismatch && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_vec_d   = stim_q;
        end
`endif
        // The verdict must include the comparison made in this final cycle.
        if (stim_q == STIM_ONES) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_next == '0);
        end else begin
          state_d    = APPLY;
          stim_d     = stim_q + 1'b1;
          hold_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      stim_q     <= '0;
      hold_cnt_q <= '0;
      mode_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
`endif
    end
  end

  assign bus.stim    = stim_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.pass    = pass_q;
  assign bus.err_cnt = err_cnt_q;
`ifdef GVT_FIRST_FAIL_CAPTURE_EN
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_vec   = fail_vec_q;
`endif

endmodule

// File: doc/gate_vector_tester.md
Name: gate_vector_tester

Overview:
Synthesisable, parametrised successor to our two-input gate test fixtures. It drives every input combination onto an N-input combinational DUT and holds each vector for a programmable number of cycles. It then samples the DUT output and compares it against a selectable reference gate function, counting mismatches. It sits beside the DUT on the board, so gate schematics can be checked on silicon without a simulator.

Parameters:
N_IN, 2, DUT input count; legal range 1..8.
HOLD, 100, clock cycles each vector is held before sampling; legal range 1..65535.
ERR_W, 8, width of the mismatch counter.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request to begin a run.
mode  input  3  reference function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 BUF(stim[0]), 7 NOT(stim[0]).
dut_out  input  1  DUT output.
stim  output  N_IN  vector applied to the DUT.
busy  output  1  run in progress.
done  output  1  run complete; held until the next start or rst.
pass  output  1  valid while done=1; set when err_cnt==0.
err_cnt  output  ERR_W  saturating mismatch count.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; stim=0, busy=0, done=0, pass=0, err_cnt=0, hold counter=0, latched mode=0. rst overrides start. A reset during a run aborts it immediately.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE:
  - start=1 -> latch mode, stim=0, hold counter=0, err_cnt=0, busy=1, next state APPLY.
- APPLY:
  - Hold counter increments each cycle.
  - When the counter reaches HOLD-1, next state is CHECK; stim is held constant throughout.
- CHECK (exactly one cycle):
  - expected = latched function of the current stim.
  - If dut_out != expected, err_cnt += 1, saturating at 2^ERR_W-1.
  - If stim is all ones -> next state DONE, busy=0, done=1, pass=(final err_cnt==0), including this cycle's comparison.
  - Otherwise stim += 1, hold counter=0, next state APPLY.
- DONE:
  - stim holds its last value (all ones).
  - start=1 -> same action as start in IDLE: done=0, pass=0, new run.
- Timing:
  - A run lasts 2^N_IN * (HOLD+1) cycles from the start edge to done rising.
  - Each vector is stable for HOLD+1 cycles.
  - dut_out is sampled in the CHECK cycle, i.e. HOLD cycles after the vector changed.
- Reduction functions (AND/OR/XOR and complements) are taken across all N_IN bits. BUF/NOT use stim[0] only. For N_IN=1, AND=OR=XOR=BUF.
- Ignored inputs:
  - start while busy=1 is ignored.
  - mode changes during a run are ignored; only the value latched at start is used.
- Illegal parameter values (N_IN=0, HOLD=0) are rejected at elaboration.

Optional Feature:
GVT_FIRST_FAIL_CAPTURE_EN
- Defined: adds outputs fail_valid (1) and fail_vec (N_IN).
  - Both reset to 0 and are cleared on start.
  - On the first mismatching CHECK of a run, fail_vec=stim and fail_valid=1. Both hold until the next start or rst.
  - Later mismatches do not overwrite the captured vector.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- N_IN=2, HOLD=4, DUT model AND, start with mode=0 -> stim steps 00,01,10,11, each held 5 cycles; done rises 20 cycles after start; err_cnt=0, pass=1.
- N_IN=2, HOLD=4, DUT model XOR, mode=0 -> mismatches at 01, 10 and 11; err_cnt=3, pass=0; with GVT_FIRST_FAIL_CAPTURE_EN, fail_vec=01 and fail_valid=1.
- N_IN=3, ERR_W=2, DUT tied to 1, mode=0 -> 7 mismatches, err_cnt saturates at 3, pass=0, done after 8*(HOLD+1) cycles.
- N_IN=2, HOLD=4, DUT model NAND, mode=3 -> pulse start mid-run and change mode to 1 mid-run -> run unaffected, err_cnt=0, pass=1.
- Assert rst during vector 10 -> next cycle stim=0, busy=0, done=0, err_cnt=0. A fresh start then completes normally in 20 cycles.
- From DONE with pass=1, pulse start with mode=7 and DUT model NOT(stim[0]) -> done and pass drop, the new run completes, pass=1.
